hdlc_rx_channel: RTL and testbench

Bit-level HDLC receive channel. Samples the serial Rx line, detects flags and aborts, removes inserted zeros, and assembles the data between an opening and a closing flag into bytes (LSB first). Sits between the Rx pin and the Rx buffer/status logic; it is the source of Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame and Rx_EoF seen by the buffer and the assertion module.

---
 rtl/hdlc_rx_channel_if.sv | 25 ++
 rtl/hdlc_rx_channel.sv | 154 +++++++++++++++
 tb/tb_hdlc_rx_channel.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hdlc_rx_channel_if.sv
// Rx-side signal bundle of the HDLC receive channel: serial line and enable in,
// detection pulses, frame status and assembled bytes out.
interface hdlc_rx_channel_if;
  logic       Rx;
  logic       RxEN;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       Rx_ValidFrame;
  logic [7:0] Rx_Data;
  logic       Rx_NewByte;
  logic       Rx_EoF;
  logic       Rx_FrameError;

  modport master (
    output Rx, RxEN,
    input  Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame,
    input  Rx_Data, Rx_NewByte, Rx_EoF, Rx_FrameError
  );

  modport slave (
    input  Rx, RxEN,
    output Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame,
    output Rx_Data, Rx_NewByte, Rx_EoF, Rx_FrameError
  );
endinterface

// File: rtl/hdlc_rx_channel.sv
// Bit-level HDLC receiver: flag/abort detection on an 8-bit line window, zero
// removal on the bit leaving the window, and LSB-first byte assembly per frame.
module hdlc_rx_channel (
  input  logic             Clk,
  input  logic             Rst,
  hdlc_rx_channel_if.slave rx_if
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  // Newest bit enters at [7], oldest sits at [0] and is the next to leave.
  localparam logic [7:0] FLAG_PAT  = 8'h7E;
  localparam logic [7:0] ABORT_PAT = 8'hFE;

  logic [7:0] window_q, window_d;
  logic [7:0] vld_q, vld_d;
  logic [0:0] state_q, state_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       got_bit_q, got_bit_d;
  logic       byte_done_q, byte_done_d;
  logic       close_q, close_d;
  logic       close_err_q, close_err_d;
  logic       flag_q, flag_d;
  logic       abort_q, abort_d;
  logic [7:0] data_q, data_d;
  logic       new_byte_q, new_byte_d;
  logic       eof_q, eof_d;
  logic       ferr_q, ferr_d;

  logic abort_det;
  logic flag_det;
  logic out_bit;
  logic stuffed;

  assign abort_det = rx_if.RxEN && (window_q == ABORT_PAT);
  assign flag_det  = rx_if.RxEN && !abort_det && (window_q == FLAG_PAT);
  assign out_bit   = window_q[0];
  assign stuffed   = (ones_q >= 3'd5) && !out_bit;

  always_comb begin
    // NOTE: every _d gets a default before any branch so no path leaves a latch.
    window_d    = window_q;
    vld_d       = vld_q;
    state_d     = state_q;
    ones_d      = ones_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    got_bit_d   = got_bit_q;
    byte_done_d = 1'b0;
    close_d     = 1'b0;
    close_err_d = 1'b0;
    flag_d      = 1'b0;
    abort_d     = 1'b0;
    new_byte_d  = byte_done_q;
    data_d      = byte_done_q ? shift_q : data_q;
    eof_d       = close_q;
    ferr_d      = close_q && close_err_q;

    if (!rx_if.RxEN) begin
      state_d   = ST_IDLE;
      ones_d    = 3'd0;
      bit_cnt_d = 3'd0;
      got_bit_d = 1'b0;
    end else begin
      window_d = {rx_if.Rx, window_q[7:1]};
      // A decoded flag/abort consumes the whole window: only the bit arriving now stays data-eligible.
      vld_d    = (abort_det || flag_det) ? 8'h80 : {1'b1, vld_q[7:1]};
      flag_d   = flag_det;
      abort_d  = abort_det;

      if (abort_det) begin
        state_d   = ST_IDLE;
        ones_d    = 3'd0;
        bit_cnt_d = 3'd0;
        got_bit_d = 1'b0;
      end else if (flag_det) begin
        ones_d    = 3'd0;
        bit_cnt_d = 3'd0;
        got_bit_d = 1'b0;
        shift_d   = 8'h00;
        if (state_q == ST_FRAME && got_bit_q) begin
          state_d     = ST_IDLE;
          close_d     = 1'b1;
          close_err_d = (bit_cnt_q != 3'd0);
        end else begin
          state_d = ST_FRAME;
        end
      end else if (vld_q[0]) begin
        if (stuffed) begin
          ones_d = 3'd0;
        end else begin
          ones_d = out_bit ? ((ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1) : 3'd0;
          if (state_q == ST_FRAME) begin
            shift_d     = {out_bit, shift_q[7:1]};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            got_bit_d   = 1'b1;
            byte_done_d = (bit_cnt_q == 3'd7);
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      window_q    <= 8'hFF;
      vld_q       <= 8'h00;
      state_q     <= ST_IDLE;
      ones_q      <= 3'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      got_bit_q   <= 1'b0;
      byte_done_q <= 1'b0;
      close_q     <= 1'b0;
      close_err_q <= 1'b0;
      flag_q      <= 1'b0;
      abort_q     <= 1'b0;
      data_q      <= 8'h00;
      new_byte_q  <= 1'b0;
      eof_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      window_q    <= window_d;
      vld_q       <= vld_d;
      state_q     <= state_d;
      ones_q      <= ones_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      got_bit_q   <= got_bit_d;
      byte_done_q <= byte_done_d;
      close_q     <= close_d;
      close_err_q <= close_err_d;
      flag_q      <= flag_d;
      abort_q     <= abort_d;
      data_q      <= data_d;
      new_byte_q  <= new_byte_d;
      eof_q       <= eof_d;
      ferr_q      <= ferr_d;
    end
  end

  assign rx_if.Rx_FlagDetect  = flag_q;
  assign rx_if.Rx_AbortDetect = abort_q;
  assign rx_if.Rx_ValidFrame  = (state_q == ST_FRAME);
  assign rx_if.Rx_Data        = data_q;
  assign rx_if.Rx_NewByte     = new_byte_q;
  assign rx_if.Rx_EoF         = eof_q;
  assign rx_if.Rx_FrameError  = ferr_q;

endmodule

// File: tb/tb_hdlc_rx_channel.sv
// Directed bench for hdlc_rx_channel: stimulus pushes timed expected events into
// a scoreboard, a negedge monitor pops and compares them every cycle.
module tb_hdlc_rx_channel;

  typedef enum logic [2:0] {EV_FLAG, EV_ABORT, EV_BYTE, EV_EOF, EV_VF} ev_kind_e;

  typedef struct {
    int unsigned edge_no;
    ev_kind_e    kind;
    logic [7:0]  data;
  } ev_t;

  localparam int ROLE_REPEAT    = 0;
  localparam int ROLE_OPEN      = 1;
  localparam int ROLE_CLOSE     = 2;
  localparam int ROLE_CLOSE_ERR = 3;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_on = 1'b0;
  ev_t         exp_q[$];
  logic        exp_vf = 1'b0;
  logic [7:0]  exp_data = 8'h00;
  int          st_ones = 0;

  hdlc_rx_channel_if bus ();

  hdlc_rx_channel dut (
    .Clk   (clk),
    .Rst   (rst),
    .rx_if (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic push_exp(input int unsigned e, input ev_kind_e k, input logic [7:0] d);
    ev_t ev;
    int  i;
    ev.edge_no = e;
    ev.kind    = k;
    ev.data    = d;
    i = 0;
    while (i < exp_q.size() &&
           (exp_q[i].edge_no < e || (exp_q[i].edge_no == e && exp_q[i].kind <= k)))
      i++;
    exp_q.insert(i, ev);
  endtask

  task automatic take(input int unsigned e, input ev_kind_e k, output bit hit, output logic [7:0] d);
    hit = 1'b0;
    d   = 8'h00;
    if (exp_q.size() > 0 && exp_q[0].edge_no == e && exp_q[0].kind == k) begin
      hit = 1'b1;
      d   = exp_q[0].data;
      exp_q.delete(0);
    end
  endtask

  // Outputs sampled mid-cycle; e is the index of the edge that would sample them.
  always @(negedge clk) begin
    int unsigned e;
    bit          hit;
    logic [7:0]  d;
    if (mon_on) begin
      e = cyc + 1;
      take(e, EV_FLAG, hit, d);
      check("flag_detect", bus.Rx_FlagDetect, hit);
      take(e, EV_ABORT, hit, d);
      check("abort_detect", bus.Rx_AbortDetect, hit);
      take(e, EV_BYTE, hit, d);
      if (hit) exp_data = d;
      check("new_byte", bus.Rx_NewByte, hit);
      check("rx_data", bus.Rx_Data, exp_data);
      take(e, EV_EOF, hit, d);
      check("eof_ferr", {bus.Rx_EoF, bus.Rx_FrameError}, hit ? {1'b1, d[0]} : 2'b00);
      take(e, EV_VF, hit, d);
      if (hit) exp_vf = d[0];
      check("valid_frame", bus.Rx_ValidFrame, exp_vf);
    end
  end

  // Drives one line bit; k is the edge that samples it.
  task automatic send_bit(input logic b, output int unsigned k);
    k = cyc + 1;
    bus.Rx = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    int unsigned k;
    repeat (n) send_bit(1'b1, k);
  endtask

  task automatic send_data_bit(input logic b, output int unsigned k);
    int unsigned ks;
    send_bit(b, k);
    if (b) begin
      st_ones++;
      if (st_ones == 5) begin
        send_bit(1'b0, ks);
        st_ones = 0;
      end
    end else begin
      st_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    int unsigned k;
    for (int i = 0; i < 8; i++) send_data_bit(v[i], k);
    push_exp(k + 10, EV_BYTE, v);
  endtask

  task automatic send_flag(input int role);
    logic [7:0]  f;
    int unsigned k;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_bit(f[i], k);
    st_ones = 0;
    push_exp(k + 2, EV_FLAG, 8'h00);
    if (role == ROLE_OPEN) push_exp(k + 2, EV_VF, 8'h01);
    if (role == ROLE_CLOSE || role == ROLE_CLOSE_ERR) begin
      push_exp(k + 2, EV_VF, 8'h00);
      push_exp(k + 3, EV_EOF, (role == ROLE_CLOSE_ERR) ? 8'h01 : 8'h00);
    end
  endtask

  task automatic send_abort(input bit in_frame);
    int unsigned k;
    send_bit(1'b0, k);
    repeat (7) send_bit(1'b1, k);
    push_exp(k + 2, EV_ABORT, 8'h00);
    if (in_frame) push_exp(k + 2, EV_VF, 8'h00);
  endtask

  task automatic set_rxen(input logic v);
    int unsigned k;
    k = cyc + 1;
    bus.RxEN = v;
    @(posedge clk);
    #1;
    if (!v) push_exp(k + 1, EV_VF, 8'h00);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_flag"},  bus.Rx_FlagDetect,  1'b0);
    check({tag, "_abort"}, bus.Rx_AbortDetect, 1'b0);
    check({tag, "_vf"},    bus.Rx_ValidFrame,  1'b0);
    check({tag, "_data"},  bus.Rx_Data,        8'h00);
    check({tag, "_nb"},    bus.Rx_NewByte,     1'b0);
    check({tag, "_eof"},   bus.Rx_EoF,         1'b0);
    check({tag, "_ferr"},  bus.Rx_FrameError,  1'b0);
  endtask

  initial begin
    int unsigned k;
    rst      = 1'b1;
    bus.Rx   = 1'b1;
    bus.RxEN = 1'b1;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_on = 1'b1;
    @(posedge clk);
    #1;

    // Idle line, opening flag, two bytes, clean close.
    idle(10);
    send_flag(ROLE_OPEN);
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_flag(ROLE_CLOSE);

    // All-ones byte carried with an inserted zero.
    send_flag(ROLE_OPEN);
    send_byte(8'hFF);
    send_flag(ROLE_CLOSE);

    // Abort after a complete byte, then idle ones (no second abort).
    send_flag(ROLE_OPEN);
    send_byte(8'h12);
    send_abort(1'b1);
    idle(12);

    // Closing flag off a byte boundary, then flag-flag-flag with no data.
    send_flag(ROLE_OPEN);
    send_byte(8'h55);
    send_data_bit(1'b1, k);
    send_data_bit(1'b0, k);
    send_data_bit(1'b1, k);
    send_flag(ROLE_CLOSE_ERR);
    send_flag(ROLE_OPEN);
    send_flag(ROLE_REPEAT);
    send_flag(ROLE_REPEAT);

    // Asynchronous reset in the middle of a byte.
    send_data_bit(1'b1, k);
    send_data_bit(1'b0, k);
    send_data_bit(1'b1, k);
    #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    exp_vf   = 1'b0;
    exp_data = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    st_ones = 0;
    idle(3);

    // Reopen, then drop RxEN mid-frame; re-enable and run a full frame.
    send_flag(ROLE_OPEN);
    send_data_bit(1'b1, k);
    send_data_bit(1'b0, k);
    send_data_bit(1'b1, k);
    set_rxen(1'b0);
    idle(4);
    set_rxen(1'b1);
    st_ones = 0;
    send_flag(ROLE_OPEN);
    send_byte(8'h3C);
    send_flag(ROLE_CLOSE);

    // Aborts while idle re-arm only after a zero.
    send_abort(1'b0);
    idle(5);
    send_abort(1'b0);
    idle(15);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
